// File: rtl/data_mem.sv
// data_mem: byte-addressable synchronous data memory with a fixed-latency,
// tagged read pipeline and a single-cycle access-fault strobe.
// Optional feature macro: DATA_MEM_PARITY_EN (per-byte even parity,
// written-since-reset flags and a par_inject input port).
module data_mem #(
    parameter int          DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_enables,
    input  logic [31:0] req_id,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic [31:0] rsp_id,
    output logic        access_fault
`ifdef DATA_MEM_PARITY_EN
    ,
    input  logic        par_inject
`endif
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam int          LAT       = READ_LATENCY;
    localparam logic [31:0] DEPTH_W32 = 32'(DEPTH_WORDS);

    // ------------------------------------------------------------------
    // Address decode. The subtraction wraps for addresses below the base,
    // so the explicit lower-bound compare is what rejects those.
    // ------------------------------------------------------------------
    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             wr_ok;

    assign offset   = address - BASE_ADDR;
    assign in_range = (address >= BASE_ADDR) && ((offset >> 2) < DEPTH_W32);
    assign idx      = offset[IDX_W+1:2];
    assign wr_ok    = write_enable & in_range;

    // ------------------------------------------------------------------
    // Storage: one byte-wide RAM per lane with a registered read port.
    // The read samples the old contents because the write is non-blocking,
    // which gives read-before-write on a same-cycle collision.
    // ------------------------------------------------------------------
    logic [31:0] rd_word;
`ifdef DATA_MEM_PARITY_EN
    logic [3:0]  par_rd;
    logic [3:0]  par_calc;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rd_byte_q;

            // Byte-lane RAM write with registered read
            always_ff @(posedge clk) begin
                if (wr_ok && byte_enables[gi]) begin
                    mem[idx] <= write_data[8*gi +: 8];
                end
                rd_byte_q <= mem[idx];
            end

            assign rd_word[8*gi +: 8] = rd_byte_q;

`ifdef DATA_MEM_PARITY_EN
            logic par_mem [DEPTH_WORDS];
            logic par_rd_q;

            // Parity RAM: even parity of the byte, optionally inverted for fault injection
            always_ff @(posedge clk) begin
                if (wr_ok && byte_enables[gi]) begin
                    par_mem[idx] <= (^write_data[8*gi +: 8]) ^ par_inject;
                end
                par_rd_q <= par_mem[idx];
            end

            assign par_rd[gi]   = par_rd_q;
            assign par_calc[gi] = ^rd_byte_q;
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Parity check on the word just read (stage 0). Only bytes written
    // since reset are checked; the flags are real flops so reset clears them.
    // ------------------------------------------------------------------
    logic par_err0;

`ifdef DATA_MEM_PARITY_EN
    logic [3:0] flag_q [DEPTH_WORDS];
    logic [3:0] flag_rd_q;

    // Written-since-reset flags per byte, read alongside the data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                flag_q[i] <= '0;
            end
            flag_rd_q <= '0;
        end else begin
            if (wr_ok) begin
                flag_q[idx] <= flag_q[idx] | byte_enables;
            end
            flag_rd_q <= flag_q[idx];
        end
    end

    assign par_err0 = |(flag_rd_q & (par_rd ^ par_calc));
`else
    assign par_err0 = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read pipeline stage 0 and the write-fault strobe
    // ------------------------------------------------------------------
    logic        valid0_q, valid0_d;
    logic        ok0_q, ok0_d;
    logic [31:0] id0_q, id0_d;
    logic        wfault_q, wfault_d;

    // Next-state for stage 0: tag is zeroed when no read so rsp_id idles at 0
    always_comb begin
        valid0_d = read_enable;
        ok0_d    = read_enable & in_range;
        id0_d    = read_enable ? req_id : '0;
        wfault_d = write_enable & ~in_range;
    end

    // Stage 0 control registers and the write-fault strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid0_q <= 1'b0;
            ok0_q    <= 1'b0;
            id0_q    <= '0;
            wfault_q <= 1'b0;
        end else begin
            valid0_q <= valid0_d;
            ok0_q    <= ok0_d;
            id0_q    <= id0_d;
            wfault_q <= wfault_d;
        end
    end

    // Per-stage views of {valid, data, id, fault}
    logic [LAT-1:0] svalid;
    logic [LAT-1:0] sfault;
    logic [31:0]    sdata [LAT];
    logic [31:0]    sid   [LAT];

    // Out-of-range reads return zero data; parity errors keep the stored word
    assign svalid[0] = valid0_q;
    assign sdata[0]  = ok0_q ? rd_word : '0;
    assign sid[0]    = id0_q;
    assign sfault[0] = (valid0_q & ~ok0_q) | (ok0_q & par_err0);

    generate
        for (gi = 1; gi < LAT; gi++) begin : g_stage
            logic        valid_q;
            logic        fault_q;
            logic [31:0] data_q;
            logic [31:0] id_q;

            // Shift one pipeline stage; reset drops any in-flight read
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_q <= 1'b0;
                    fault_q <= 1'b0;
                    data_q  <= '0;
                    id_q    <= '0;
                end else begin
                    valid_q <= svalid[gi-1];
                    fault_q <= sfault[gi-1];
                    data_q  <= sdata[gi-1];
                    id_q    <= sid[gi-1];
                end
            end

            assign svalid[gi] = valid_q;
            assign sfault[gi] = fault_q;
            assign sdata[gi]  = data_q;
            assign sid[gi]    = id_q;
        end
    endgenerate

    // Outputs come from the last stage; a write fault may coincide with a response
    assign read_valid   = svalid[LAT-1];
    assign read_data    = sdata[LAT-1];
    assign rsp_id       = sid[LAT-1];
    assign access_fault = sfault[LAT-1] | wfault_q;

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard testbench for data_mem (DEPTH_WORDS=16, BASE_ADDR=0x1000,
// READ_LATENCY=3). Stimulus pushes expected responses; a monitor pops and
// compares them every cycle. Parity checks are enabled with DATA_MEM_PARITY_EN.
module tb_data_mem;

    localparam int          DW   = 16;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          LAT  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] address = '0;
    logic        read_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [31:0] write_data = '0;
    logic [3:0]  byte_enables = '0;
    logic [31:0] req_id = '0;
    logic [31:0] read_data;
    logic        read_valid;
    logic [31:0] rsp_id;
    logic        access_fault;
`ifdef DATA_MEM_PARITY_EN
    logic        par_inject = 1'b0;
`endif

    always #5 clk = ~clk;

    data_mem #(
        .DEPTH_WORDS (DW),
        .BASE_ADDR   (BASE),
        .READ_LATENCY(LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .read_enable (read_enable),
        .write_enable(write_enable),
        .write_data  (write_data),
        .byte_enables(byte_enables),
        .req_id      (req_id),
        .read_data   (read_data),
        .read_valid  (read_valid),
        .rsp_id      (rsp_id),
        .access_fault(access_fault)
`ifdef DATA_MEM_PARITY_EN
        ,
        .par_inject  (par_inject)
`endif
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [31:0] id;
        logic        fault;
    } exp_t;

    exp_t rsp_q[$];
    int   wf_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt = 0;

    // Monitor: every cycle the outputs must match exactly what is due now
    always @(posedge clk) begin
        exp_t        e;
        logic        have;
        logic        wf;
        logic [31:0] xd;
        logic [31:0] xi;
        logic        xf;
        edge_cnt++;
        #2;
        while (rsp_q.size() > 0 && rsp_q[0].due < edge_cnt) begin
            e = rsp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_rsp id=%0d due=%0d: got nothing, required a response", e.id, e.due);
        end
        have = (rsp_q.size() > 0) && (rsp_q[0].due == edge_cnt);
        wf   = (wf_q.size() > 0) && (wf_q[0] == edge_cnt);
        e    = '{due: 0, data: '0, id: '0, fault: 1'b0};
        if (have) e = rsp_q.pop_front();
        if (wf) void'(wf_q.pop_front());
        xd = have ? e.data : 32'h0;
        xi = have ? e.id : 32'h0;
        xf = (have && e.fault) || wf;
        checks++;
        if (read_valid !== have || read_data !== xd || rsp_id !== xi || access_fault !== xf) begin
            failures++;
            $display("FAIL %s cyc=%0d: got v=%0b d=%h id=%0d f=%0b, required v=%0b d=%h id=%0d f=%0b",
                     have ? "read_rsp" : (wf ? "write_fault" : "idle_outputs"), edge_cnt,
                     read_valid, read_data, rsp_id, access_fault, have, xd, xi, xf);
        end else if (have || wf) begin
            $display("RSP cyc=%0d v=%0b d=%h id=%0d f=%0b ok", edge_cnt,
                     read_valid, read_data, rsp_id, access_fault);
        end
    end

    // One request cycle; expectation is due LAT-1 edges after the sampling edge
    task automatic req(input logic rd, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input logic [31:0] id,
                       input logic inj, input logic [31:0] xdata, input logic xfault,
                       input logic xwf);
        @(negedge clk);
        read_enable  = rd;
        write_enable = we;
        address      = addr;
        write_data   = wd;
        byte_enables = be;
        req_id       = id;
`ifdef DATA_MEM_PARITY_EN
        par_inject   = inj;
`else
        if (inj) $display("note: parity injection has no effect in this build");
`endif
        if (rd) rsp_q.push_back('{due: edge_cnt + LAT, data: xdata, id: id, fault: xfault});
        if (xwf) wf_q.push_back(edge_cnt + 1);
        $display("REQ cyc=%0d rd=%0b we=%0b addr=%h wd=%h be=%b id=%0d", edge_cnt + 1,
                 rd, we, addr, wd, be, id);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            read_enable  = 1'b0;
            write_enable = 1'b0;
            address      = '0;
            write_data   = '0;
            byte_enables = '0;
            req_id       = '0;
`ifdef DATA_MEM_PARITY_EN
            par_inject   = 1'b0;
`endif
        end
    endtask

    initial begin
        // Reset: outputs checked as zero by the monitor throughout
        #1 rst = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(1);

        // Fill words 0..7, then eight back-to-back reads with ids 0..7
        for (int i = 0; i < 8; i++)
            req(1'b0, 1'b1, BASE + 32'(4 * i), 32'h1000_0000 + 32'(i) * 32'h0101_0101,
                4'hF, 0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            req(1'b1, 1'b0, BASE + 32'(4 * i), 0, 4'h0, 32'(i), 1'b0,
                32'h1000_0000 + 32'(i) * 32'h0101_0101, 1'b0, 1'b0);
        idle(1);

        // Full-word write then read
        req(1'b0, 1'b1, BASE + 32'd8, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 0, 1'b0, 1'b0);
        req(1'b1, 1'b0, BASE + 32'd8, 0, 4'h0, 7, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        // Low address bits ignored
        req(1'b1, 1'b0, BASE + 32'd11, 0, 4'h0, 9, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Partial write
        req(1'b0, 1'b1, BASE + 32'd12, 32'h1122_3344, 4'hF, 0, 1'b0, 0, 1'b0, 1'b0);
        req(1'b0, 1'b1, BASE + 32'd12, 32'hAABB_CCDD, 4'b0101, 0, 1'b0, 0, 1'b0, 1'b0);
        req(1'b1, 1'b0, BASE + 32'd12, 0, 4'h0, 8, 1'b0, 32'h11BB_33DD, 1'b0, 1'b0);

        // Same-cycle read and write: read-before-write, then the new value
        req(1'b0, 1'b1, BASE + 32'd36, 32'h0, 4'hF, 0, 1'b0, 0, 1'b0, 1'b0);
        req(1'b1, 1'b1, BASE + 32'd36, 32'h5555_5555, 4'hF, 20, 1'b0, 32'h0, 1'b0, 1'b0);
        req(1'b1, 1'b0, BASE + 32'd36, 0, 4'h0, 21, 1'b0, 32'h5555_5555, 1'b0, 1'b0);
        // byte_enables=0 is a no-op without fault
        req(1'b0, 1'b1, BASE + 32'd36, 32'hAAAA_AAAA, 4'h0, 0, 1'b0, 0, 1'b0, 1'b0);
        req(1'b1, 1'b0, BASE + 32'd36, 0, 4'h0, 22, 1'b0, 32'h5555_5555, 1'b0, 1'b0);
        idle(1);

        // Range faults: just past the end, just below the base
        req(1'b1, 1'b0, BASE + 32'(4 * DW), 0, 4'h0, 30, 1'b0, 32'h0, 1'b1, 1'b0);
        req(1'b1, 1'b0, BASE - 32'd4, 0, 4'h0, 31, 1'b0, 32'h0, 1'b1, 1'b0);
        req(1'b0, 1'b1, BASE - 32'd4, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 0, 1'b0, 1'b1);
        idle(1);
        req(1'b1, 1'b0, BASE, 0, 4'h0, 32, 1'b0, 32'h1000_0000, 1'b0, 1'b0);
        idle(1);

        // Last word is in range; a write fault coinciding with its response ORs in
        req(1'b0, 1'b1, BASE + 32'(4 * DW - 4), 32'hCAFE_0015, 4'hF, 0, 1'b0, 0, 1'b0, 1'b0);
        req(1'b1, 1'b0, BASE + 32'(4 * DW - 4), 0, 4'h0, 40, 1'b0, 32'hCAFE_0015, 1'b0, 1'b0);
        idle(1);
        req(1'b0, 1'b1, BASE + 32'(4 * DW), 32'h1234_0000, 4'hF, 0, 1'b0, 0, 1'b0, 1'b1);
        idle(LAT + 1);

`ifdef DATA_MEM_PARITY_EN
        // Injected parity error faults with valid data; clean write does not
        req(1'b0, 1'b1, BASE + 32'd40, 32'h1234_5678, 4'hF, 0, 1'b1, 0, 1'b0, 1'b0);
        req(1'b1, 1'b0, BASE + 32'd40, 0, 4'h0, 60, 1'b0, 32'h1234_5678, 1'b1, 1'b0);
        req(1'b0, 1'b1, BASE + 32'd44, 32'h8765_4321, 4'hF, 0, 1'b0, 0, 1'b0, 1'b0);
        req(1'b1, 1'b0, BASE + 32'd44, 0, 4'h0, 61, 1'b0, 32'h8765_4321, 1'b0, 1'b0);
        idle(LAT + 1);
`endif

        // Reset mid-read: the in-flight response must never appear
        req(1'b1, 1'b0, BASE, 0, 4'h0, 50, 1'b0, 32'h1000_0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        read_enable = 1'b0;
        rsp_q.delete();
        wf_q.delete();
        $display("RST asserted cyc=%0d, in-flight read id=50 discarded", edge_cnt);
        idle(LAT + 2);
        rst = 1'b1;

        // Operation resumes after reset
        req(1'b0, 1'b1, BASE + 32'd4, 32'h0000_0077, 4'hF, 0, 1'b0, 0, 1'b0, 1'b0);
        req(1'b1, 1'b0, BASE + 32'd4, 0, 4'h0, 70, 1'b0, 32'h0000_0077, 1'b0, 1'b0);
`ifdef DATA_MEM_PARITY_EN
        // Flags cleared by reset: the bad-parity word is no longer checked
        req(1'b1, 1'b0, BASE + 32'd40, 0, 4'h0, 71, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
`endif
        idle(LAT + 3);

        checks++;
        if (rsp_q.size() != 0 || wf_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d responses and %0d write faults outstanding, required 0",
                     rsp_q.size(), wf_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem.md
# data_mem

Byte-addressable synchronous data memory that sits directly downstream of the memory controller and services its read and write requests. It accepts one request per cycle with no back-pressure. It returns read data after a fixed, parameterised latency together with a response tag, and it flags out-of-range accesses.

## Interface

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, minimum 4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; word-aligned.
- READ_LATENCY, 1: cycles from read request to response; legal range 1..4.

Ports:
- clk  input  1  single clock; all state on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- address  input  32  byte address; bits [1:0] ignored.
- read_enable  input  1  read request this cycle.
- write_enable  input  1  write request this cycle.
- write_data  input  32  write data; byte i is bits [8i+7:8i].
- byte_enables  input  4  per-byte write mask; ignored on reads.
- req_id  input  32  request tag; sampled on read requests only.
- read_data  output  32  read response data; 0 whenever read_valid is low.
- read_valid  output  1  one-cycle response strobe.
- rsp_id  output  32  req_id of the request being answered; 0 whenever read_valid is low.
- access_fault  output  1  one-cycle fault strobe.

## Operation

- Word index is (address - BASE_ADDR) >> 2.
- An access is in range when address >= BASE_ADDR and the word index < DEPTH_WORDS.

Writes:
- An in-range write updates only the bytes whose byte_enables bit is 1, at the clock edge where write_enable is sampled.
- byte_enables = 4'b0000 is a legal no-op and does not fault.
- An out-of-range write changes no storage. access_fault goes high on the following cycle, with read_valid low.

Reads:
- Every sampled read_enable produces exactly one response, READ_LATENCY cycles later.
- The response always returns the full word.
- An in-range response has read_valid=1, read_data=word, rsp_id=req_id and access_fault=0.
- An out-of-range response has read_valid=1, read_data=0, rsp_id=req_id and access_fault=1, all in the same cycle.

Ordering and hazards:
- The read pipeline is a shift register of READ_LATENCY stages, each holding {valid, data, id, fault}.
- Back-to-back reads every cycle are fully supported, with no bubbles.
- Read and write in the same cycle: both are performed. The read returns the pre-write contents (read-before-write).
- A read in any cycle after a write returns the written data.
- A write-fault strobe and a read response may land in the same cycle. access_fault is then the OR of the two.

Reset:
- All outputs are 0 and all pipeline stages are invalid. Reset does not clear storage, so contents are undefined until written.
- Reset asserted mid-operation discards in-flight reads; no response is ever issued for them.
- The first request is accepted on the first rising edge with rst high.

## Timing

- Read latency is exactly READ_LATENCY cycles. A request sampled at edge N responds in the cycle after edge N+READ_LATENCY-1.
- With READ_LATENCY=1, the response is visible in the cycle immediately after the request.
- The write-fault strobe appears one cycle after the request, independent of READ_LATENCY.
- Throughput is one request per cycle. There is no ready signal, and the block never stalls.
- All outputs are driven from flops, so there is no combinational input-to-output path.

## Configuration

- DATA_MEM_PARITY_EN defined:
  - Each byte stores an even-parity bit plus a written flag. Written flags are flops cleared by reset.
  - An extra input, par_inject (1 bit), inverts the stored parity of every byte written in that cycle.
  - On an in-range read, any byte whose flag is set and whose parity mismatches raises access_fault with read_valid=1. read_data still carries the stored word.
  - Bytes never written since reset are not parity-checked.
- DATA_MEM_PARITY_EN undefined: there is no parity storage and no par_inject port. access_fault reports range faults only.

## Test plan

- Full-word write then read: write 32'hDEAD_BEEF to BASE_ADDR+8 with byte_enables=4'hF, then read with req_id=7 -> READ_LATENCY cycles later: read_valid=1, read_data=32'hDEAD_BEEF, rsp_id=7, access_fault=0.
- Partial write: write 32'h1122_3344 with byte_enables=4'hF, then write 32'hAABB_CCDD with byte_enables=4'b0101, then read -> read_data=32'h11BB_33DD.
- Pipelined reads: read words 0..7 in eight consecutive cycles with READ_LATENCY=3 -> eight consecutive read_valid cycles in order, rsp_id=0..7, no gaps.
- Simultaneous read and write to the same word: word holds 32'h0, same cycle writes 32'h5555_5555 and reads -> response returns 32'h0; the next read returns 32'h5555_5555.
- Range faults:
  - Read at BASE_ADDR + 4*DEPTH_WORDS -> read_valid=1, read_data=0, access_fault=1.
  - Write at BASE_ADDR-4 -> access_fault=1 one cycle later, read_valid=0, and a follow-up read of word 0 is unchanged.
- Reset mid-read: issue a read, assert rst before the response cycle -> no read_valid is ever seen, and all outputs are 0 during reset. With DATA_MEM_PARITY_EN defined, writing with par_inject=1 then reading -> access_fault=1 together with read_valid=1.
